rename_dispatch: RTL and testbench
==================================

// Module: rename_dispatch
// PURPOSE
//  Register-rename/dispatch stage feeding the instruction queue. Maps arch regs rs/rt/rw to phys
//  regs via a speculative RAT and a circular free list, then registers one renamed entry per cycle.
//  Commit port returns old phys regs; flush restores RAT from the retirement RAT (RRAT).
// PARAMETERS
//  NUM_AREG   32  architectural registers ($0 hardwired)
//  NUM_PREG   64  physical registers; free-list depth FL_DEPTH = NUM_PREG-NUM_AREG
//  PAYLOAD_W  64  opaque ALU/control payload carried to instr queue
// PORTS
//  clk            in   1          clock
//  rst            in   1          reset: asynchronous, active-high
//  in_valid       in   1          decoded instr valid
//  in_ready       out  1          stage accepts instr this cycle
//  in_pc          in   32         instr PC
//  in_rs,in_rt    in   5 each     source arch regs
//  in_rw          in   5          dest arch reg
//  in_uses_rw     in   1          instr writes rw
//  in_payload     in   PAYLOAD_W  pass-through fields
//  out_valid      out  1          renamed entry valid
//  out_ready      in   1          instr queue accepts entry
//  out_pc         out  32         registered in_pc
//  out_prs,out_prt out PREG_W     phys sources
//  out_prw        out  PREG_W     new phys dest
//  out_old_prw    out  PREG_W     previous mapping of rw (freed at commit)
//  out_uses_rw    out  1          effective dest-write flag (0 when rw==0)
//  out_payload    out  PAYLOAD_W  registered in_payload
//  commit_valid   in   1          one instr retires
//  commit_uses_rw in   1          retiring instr allocated a preg
//  commit_arch_rw in   5          its arch dest
//  commit_prw     in   PREG_W     its phys dest (written to RRAT)
//  commit_old_prw in   PREG_W     preg pushed back to free list
//  flush          in   1          squash all speculative state
// BEHAVIOUR
//  - Reset: RAT[i]=RRAT[i]=i; free list holds NUM_AREG..NUM_PREG-1 in order; spec_head=commit_head=0,
//    tail=FL_DEPTH (full); all out_* = 0.
//  - alloc = in_uses_rw && in_rw!=0. $0 never renamed: always preg 0, never allocates.
//  - in_ready = !flush && (!out_valid || out_ready) && (!alloc || !fl_empty). Fire = in_valid&&in_ready.
//  - Fire: out regs load next edge (latency 1). Sources read RAT before this cycle's dest update
//    (rs==rw reads old mapping). If alloc: out_prw=fl[spec_head], out_old_prw=RAT[rw],
//    RAT[rw]<=out_prw, spec_head++. Else out_prw=0, out_old_prw=0.
//  - out_valid held with stable outputs while !out_ready; cleared on accept without new fire.
//  - Commit (commit_valid&&commit_uses_rw): RRAT[arch_rw]<=commit_prw; fl[tail]<=commit_old_prw;
//    tail++; commit_head++. commit_arch_rw==0 with uses_rw is illegal (assertion).
//  - Pointers are $clog2(FL_DEPTH)+1 bits; empty when spec_head==tail; wrap bit handles wrap-around.
//  - Flush: next edge RAT<=RRAT_next (includes same-cycle commit), spec_head<=commit_head_next,
//    out_valid<=0; no fire that cycle. Same-cycle commit still pushes the freed preg.
//  - Commit and fire in same cycle both take effect; a preg pushed this cycle is allocatable next cycle.
//  - Async rst mid-operation discards everything and returns to reset state.
// CONFIGURATION
//  RENAME_PERF_CNT_EN defined: adds output fl_stall_cnt[31:0], saturating count of cycles with
//    in_valid && alloc && fl_empty && !flush; reset 0, not cleared by flush.
//  Undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package rename_pkg: NUM_AREG, NUM_PREG, PREG_W, preg_t, rename_entry_t (the out_* bundle).
//  Sub-module rename_free_list: circular buffer with spec_head/commit_head/tail, pop/push/recover.
//  RAT/RRAT stay in rename_dispatch.
// TESTING
//  1 Reset, rename rs=1 rt=2 rw=8 -> prs=1 prt=2 prw=32 old_prw=8, out_valid 1 cycle later.
//  2 Back-to-back rw=8 twice, second rs=8 -> second prs=32, prw=33, old_prw=32.
//  3 32 allocating renames, no commits -> in_ready=0 on 33rd; commit old_prw=8 -> next alloc prw=8.
//  4 Rename rw=3(->32), rw=4(->33); commit first only; flush -> RAT[3]=32, RAT[4]=4, next alloc prw=33.
//  5 rw=0 with uses_rw=1 -> out_uses_rw=0, prw=0, spec_head unchanged.
//  6 out_ready=0 for 5 cycles -> outputs stable, in_ready=0; flush mid-stall -> out_valid=0 next edge.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared definitions for the rename/dispatch stage.
// Holds the architectural/physical register counts, the derived widths, the
// physical-register and free-list pointer types, the renamed-entry bundle that
// leaves the stage, and the free-list empty test.
package rename_pkg;

  localparam int NUM_AREG  = 32;
  localparam int NUM_PREG  = 64;
  localparam int PAYLOAD_W = 64;
  localparam int FL_DEPTH  = NUM_PREG - NUM_AREG;
  localparam int PREG_W    = $clog2(NUM_PREG);
  localparam int AREG_W    = $clog2(NUM_AREG);
  // One extra pointer bit tells a full ring apart from an empty one.
  localparam int PTR_W     = $clog2(FL_DEPTH) + 1;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;

  typedef struct packed {
    logic [31:0]          pc;
    preg_t                prs;
    preg_t                prt;
    preg_t                prw;
    preg_t                old_prw;
    logic                 uses_rw;
    logic [PAYLOAD_W-1:0] payload;
  } rename_entry_t;

  // Pointers include the wrap bit, so equality means nothing is left to allocate.
  function automatic logic fl_is_empty(input fl_ptr_t head, input fl_ptr_t tail);
    return head == tail;
  endfunction

endpackage

// File: rtl/rename_dispatch_chk.sv
// Protocol checker for rename_dispatch: a retiring instruction that claims a
// destination must not name $0, which is never renamed.
// Ports: clk, rst, and the commit port fields it observes.
module rename_dispatch_chk
  import rename_pkg::*;
(
  input logic  clk,
  input logic  rst,
  input logic  commit_valid,
  input logic  commit_uses_rw,
  input areg_t commit_arch_rw
);

  a_commit_no_r0: assert property (@(posedge clk) disable iff (rst)
    !(commit_valid && commit_uses_rw && (commit_arch_rw == areg_t'(0))));

endmodule

// File: rtl/rename_free_list.sv
// Circular free list of physical registers.
// spec_head : next preg handed out by rename (speculative)
// commit_head: spec_head as it would be if only retired instructions had allocated
// tail      : where retiring instructions return their old preg
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   pop         rename allocates head_preg this cycle
//   push        an allocating instruction retires (push + advance commit_head)
//   push_preg   preg returned by the retiring instruction
//   recover     flush: spec_head rewinds to commit_head (including this cycle's push)
//   head_preg   preg at spec_head
//   empty       nothing allocatable
module rename_free_list
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  pop,
  input  logic  push,
  input  preg_t push_preg,
  input  logic  recover,
  output preg_t head_preg,
  output logic  empty
);

  localparam int IDX_W = PTR_W - 1;

  preg_t   fl [FL_DEPTH];
  fl_ptr_t spec_head;
  fl_ptr_t commit_head;
  fl_ptr_t tail;
  fl_ptr_t commit_head_next;

  assign commit_head_next = push ? commit_head + fl_ptr_t'(1) : commit_head;
  assign head_preg        = fl[spec_head[IDX_W-1:0]];
  assign empty            = fl_is_empty(spec_head, tail);

  // Ring storage and the three pointers; reset leaves pregs NUM_AREG.. queued in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl[i] <= preg_t'(NUM_AREG + i);
      end
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= fl_ptr_t'(FL_DEPTH);
    end else begin
      if (push) begin
        fl[tail[IDX_W-1:0]] <= push_preg;
        tail                <= tail + fl_ptr_t'(1);
      end
      commit_head <= commit_head_next;
      if (recover) begin
        spec_head <= commit_head_next;
      end else if (pop) begin
        spec_head <= spec_head + fl_ptr_t'(1);
      end
    end
  end

endmodule

// File: rtl/rename_dispatch.sv
// Register rename / dispatch stage.
// Maps arch sources/dest to physical registers through the speculative RAT and
// the free list and registers one renamed entry per cycle (valid/ready on both
// sides). The commit port updates the retirement RAT and returns old pregs;
// flush restores the RAT from the retirement RAT.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready              decoded instruction handshake
//   in_pc, in_rs, in_rt, in_rw     instruction PC and arch registers
//   in_uses_rw, in_payload         dest-write flag, opaque pass-through
//   out_valid/out_ready            renamed entry handshake to the instr queue
//   out_pc, out_prs, out_prt       registered PC and phys sources
//   out_prw, out_old_prw           new phys dest and its previous mapping
//   out_uses_rw, out_payload       effective dest-write flag, payload
//   commit_*                       retiring instruction
//   flush                          squash speculative state
// Option: define RENAME_PERF_CNT_EN to add fl_stall_cnt, a saturating count of
// cycles where an allocating instruction waits on an empty free list.
module rename_dispatch
  import rename_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic [AREG_W-1:0]    in_rs,
  input  logic [AREG_W-1:0]    in_rt,
  input  logic [AREG_W-1:0]    in_rw,
  input  logic                 in_uses_rw,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [PREG_W-1:0]    out_prs,
  output logic [PREG_W-1:0]    out_prt,
  output logic [PREG_W-1:0]    out_prw,
  output logic [PREG_W-1:0]    out_old_prw,
  output logic                 out_uses_rw,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 commit_valid,
  input  logic                 commit_uses_rw,
  input  logic [AREG_W-1:0]    commit_arch_rw,
  input  logic [PREG_W-1:0]    commit_prw,
  input  logic [PREG_W-1:0]    commit_old_prw,
  input  logic                 flush
`ifdef RENAME_PERF_CNT_EN
  ,
  output logic [31:0]          fl_stall_cnt
`endif
);

  preg_t         rat       [NUM_AREG];
  preg_t         rrat      [NUM_AREG];
  preg_t         rrat_next [NUM_AREG];
  rename_entry_t entry_d;
  rename_entry_t entry_q;
  logic          alloc;
  logic          fire;
  logic          commit;
  logic          fl_empty;
  preg_t         fl_head;

  // $0 is hardwired, so it never takes a preg even when the instruction writes it.
  assign alloc    = in_uses_rw && (in_rw != areg_t'(0));
  assign commit   = commit_valid && commit_uses_rw;
  assign in_ready = !flush && (!out_valid || out_ready) && (!alloc || !fl_empty);
  assign fire     = in_valid && in_ready;

  rename_free_list u_free_list (
    .clk       (clk),
    .rst       (rst),
    .pop       (fire && alloc),
    .push      (commit),
    .push_preg (commit_old_prw),
    .recover   (flush),
    .head_preg (fl_head),
    .empty     (fl_empty)
  );

  rename_dispatch_chk u_chk (
    .clk            (clk),
    .rst            (rst),
    .commit_valid   (commit_valid),
    .commit_uses_rw (commit_uses_rw),
    .commit_arch_rw (commit_arch_rw)
  );

  // Retirement RAT after this cycle's commit; flush copies this, so a same-cycle commit is kept.
  always_comb begin
    for (int i = 0; i < NUM_AREG; i++) begin
      rrat_next[i] = (commit && (commit_arch_rw == areg_t'(i)) && (i != 0)) ? commit_prw : rrat[i];
    end
  end

  // Renamed entry; sources read the RAT before this cycle's dest update (rs==rw sees the old preg).
  always_comb begin
    entry_d         = '0;
    entry_d.pc      = in_pc;
    entry_d.prs     = rat[in_rs];
    entry_d.prt     = rat[in_rt];
    entry_d.uses_rw = alloc;
    entry_d.payload = in_payload;
    if (alloc) begin
      entry_d.prw     = fl_head;
      entry_d.old_prw = rat[in_rw];
    end else begin
      entry_d.prw     = preg_t'(0);
      entry_d.old_prw = preg_t'(0);
    end
  end

  // Speculative and retirement RATs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        rat[i]  <= preg_t'(i);
        rrat[i] <= preg_t'(i);
      end
    end else begin
      for (int i = 0; i < NUM_AREG; i++) begin
        rrat[i] <= rrat_next[i];
      end
      if (flush) begin
        for (int i = 0; i < NUM_AREG; i++) begin
          rat[i] <= rrat_next[i];
        end
      end else if (fire && alloc) begin
        rat[in_rw] <= fl_head;
      end
    end
  end

  // Output register: holds steady while the instr queue stalls, dropped on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      entry_q   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      entry_q   <= entry_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc      = entry_q.pc;
  assign out_prs     = entry_q.prs;
  assign out_prt     = entry_q.prt;
  assign out_prw     = entry_q.prw;
  assign out_old_prw = entry_q.old_prw;
  assign out_uses_rw = entry_q.uses_rw;
  assign out_payload = entry_q.payload;

`ifdef RENAME_PERF_CNT_EN
  // Free-list stall counter; saturates and survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fl_stall_cnt <= 32'd0;
    end else if (in_valid && alloc && fl_empty && !flush && (fl_stall_cnt != 32'hFFFF_FFFF)) begin
      fl_stall_cnt <= fl_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_dispatch.sv
module tb_rename_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = 32'd0;
  logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rw = 5'd0;
  logic        in_uses_rw = 1'b0;
  logic [63:0] in_payload = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [5:0]  out_prs, out_prt, out_prw, out_old_prw;
  logic        out_uses_rw;
  logic [63:0] out_payload;
  logic        commit_valid = 1'b0, commit_uses_rw = 1'b0;
  logic [4:0]  commit_arch_rw = 5'd0;
  logic [5:0]  commit_prw = 6'd0, commit_old_prw = 6'd0;
  logic        flush = 1'b0;
`ifdef RENAME_PERF_CNT_EN
  logic [31:0] fl_stall_cnt;
`endif

  rename_dispatch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs(in_rs), .in_rt(in_rt), .in_rw(in_rw), .in_uses_rw(in_uses_rw), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_prs(out_prs), .out_prt(out_prt), .out_prw(out_prw), .out_old_prw(out_old_prw),
    .out_uses_rw(out_uses_rw), .out_payload(out_payload),
    .commit_valid(commit_valid), .commit_uses_rw(commit_uses_rw), .commit_arch_rw(commit_arch_rw),
    .commit_prw(commit_prw), .commit_old_prw(commit_old_prw), .flush(flush)
`ifdef RENAME_PERF_CNT_EN
    , .fl_stall_cnt(fl_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    int          prs, prt, prw, old;
    bit          uses;
    logic [63:0] payload;
  } exp_t;
  typedef struct { int rw; int prw; int old; } infl_t;

  int    rat [32];
  int    rrat[32];
  int    fl_q[$];     // free-list contents from the retired head to the tail, in order
  int    spec_off;    // how many of fl_q are already handed out speculatively
  exp_t  sb[$];       // scoreboard: entry expected in the output register
  infl_t inflight[$]; // allocating instrs renamed but not yet retired, program order
  bit    m_ov;
  bit    last_ready;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin rat[i] = i; rrat[i] = i; end
    fl_q.delete();
    for (int i = 32; i < 64; i++) fl_q.push_back(i);
    spec_off = 0;
    sb.delete();
    inflight.delete();
    m_ov = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; commit_valid = 1'b0; commit_uses_rw = 1'b0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_prw", 64'(out_prw), 64'd0);
    chk("reset_out_pc", 64'(out_pc), 64'd0);
    chk("reset_out_payload", out_payload, 64'd0);
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input bit v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
                     input bit u, input bit ordy, input bit cm, input bit fl);
    exp_t  e;
    infl_t c;
    bit    alloc, empty, exp_ready, fire, do_commit;
    in_valid = v; in_rs = rs; in_rt = rt; in_rw = rw; in_uses_rw = u;
    in_pc = $urandom; in_payload = {$urandom, $urandom};
    out_ready = ordy; flush = fl;
    do_commit = cm && (inflight.size() > 0);
    if (do_commit) begin
      c = inflight[0];
      commit_valid = 1'b1; commit_uses_rw = 1'b1;
      commit_arch_rw = 5'(c.rw); commit_prw = 6'(c.prw); commit_old_prw = 6'(c.old);
    end else begin
      commit_valid = 1'b0; commit_uses_rw = 1'b0;
      commit_arch_rw = 5'd0; commit_prw = 6'd0; commit_old_prw = 6'd0;
    end
    alloc = u && (rw != 5'd0);
    empty = (spec_off >= fl_q.size());
    exp_ready = !fl && (!m_ov || ordy) && (!alloc || !empty);
    fire = v && exp_ready;
    e.pc = in_pc; e.payload = in_payload; e.uses = alloc;
    e.prs = rat[rs]; e.prt = rat[rt];
    e.prw = (alloc && !empty) ? fl_q[spec_off] : 0;
    e.old = alloc ? rat[rw] : 0;
    @(negedge clk);
    last_ready = in_ready;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    @(posedge clk);
    if (fl && m_ov && !ordy && sb.size() > 0) void'(sb.pop_front());
    if (do_commit) begin
      rrat[c.rw] = c.prw;
      fl_q.push_back(c.old);
      void'(fl_q.pop_front());
      spec_off--;
      void'(inflight.pop_front());
    end
    if (fire) begin
      sb.push_back(e);
      if (alloc) begin
        rat[rw] = e.prw;
        spec_off++;
        inflight.push_back('{rw: int'(rw), prw: e.prw, old: e.old});
      end
    end
    if (fl) begin
      rat = rrat;
      spec_off = 0;
      inflight.delete();
    end
    m_ov = fl ? 1'b0 : (fire ? 1'b1 : (ordy ? 1'b0 : m_ov));
    #1;
  endtask

  // Monitor: the output register must always match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (out_valid && sb.size() != 0) begin
      e = sb[0];
      chk("out_pc", 64'(out_pc), 64'(e.pc));
      chk("out_prs", 64'(out_prs), 64'(e.prs));
      chk("out_prt", 64'(out_prt), 64'(e.prt));
      chk("out_prw", 64'(out_prw), 64'(e.prw));
      chk("out_old_prw", 64'(out_old_prw), 64'(e.old));
      chk("out_uses_rw", 64'(out_uses_rw), 64'(e.uses));
      chk("out_payload", out_payload, e.payload);
      if (out_ready) void'(sb.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();

    // first rename and back-to-back dependency
    cyc(1, 5'd1, 5'd2, 5'd8, 1, 1, 0, 0);
    chk("t1_prs", 64'(out_prs), 64'd1);
    chk("t1_prt", 64'(out_prt), 64'd2);
    chk("t1_prw", 64'(out_prw), 64'd32);
    chk("t1_old_prw", 64'(out_old_prw), 64'd8);
    chk("t1_valid", 64'(out_valid), 64'd1);
    cyc(1, 5'd8, 5'd0, 5'd8, 1, 1, 0, 0);
    chk("t2_prs", 64'(out_prs), 64'd32);
    chk("t2_prw", 64'(out_prw), 64'd33);
    chk("t2_old_prw", 64'(out_old_prw), 64'd32);
    // $0 destination never allocates
    cyc(1, 5'd5, 5'd6, 5'd0, 1, 1, 0, 0);
    chk("t5_uses_rw", 64'(out_uses_rw), 64'd0);
    chk("t5_prw", 64'(out_prw), 64'd0);
    cyc(1, 5'd0, 5'd0, 5'd9, 1, 1, 0, 0);
    chk("t5_next_prw", 64'(out_prw), 64'd34);

    // exhaust the free list, then free one preg
    do_reset();
    for (int i = 0; i < 32; i++) cyc(1, 5'd0, 5'd0, 5'(((i + 7) % 31) + 1), 1, 1, 0, 0);
    cyc(1, 5'd0, 5'd0, 5'd5, 1, 1, 0, 0);
    chk("t3_full_stall", 64'(last_ready), 64'd0);
    cyc(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);
    cyc(1, 5'd0, 5'd0, 5'd10, 1, 1, 0, 0);
    chk("t3_recycled_prw", 64'(out_prw), 64'd8);

    // flush after partial retirement
    do_reset();
    cyc(1, 5'd0, 5'd0, 5'd3, 1, 1, 0, 0);
    cyc(1, 5'd0, 5'd0, 5'd4, 1, 1, 0, 0);
    cyc(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);
    cyc(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
    cyc(1, 5'd3, 5'd4, 5'd5, 1, 1, 0, 0);
    chk("t4_prs", 64'(out_prs), 64'd32);
    chk("t4_prt", 64'(out_prt), 64'd4);
    chk("t4_prw", 64'(out_prw), 64'd33);

    // output stall then flush while stalled
    do_reset();
    cyc(1, 5'd1, 5'd2, 5'd7, 1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 5'd3, 5'd4, 5'd9, 1, 0, 0, 0);
      chk("t6_stall_ready", 64'(last_ready), 64'd0);
      chk("t6_stall_prw", 64'(out_prw), 64'd32);
    end
    cyc(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    chk("t6_flush_valid", 64'(out_valid), 64'd0);

    // randomized traffic with a reset in the middle
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] r_rw;
      if (n == 1500) do_reset();
      r_rw = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cyc($urandom_range(0, 9) < 8, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), r_rw,
          $urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3);
    end

    in_valid = 1'b0; flush = 1'b0; commit_valid = 1'b0; commit_uses_rw = 1'b0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
